// File: rtl/sram_test_master_if.sv
// Avalon-MM bus between the SRAM test master and the SRAM slave.
// Read data is registered by the slave and arrives one cycle after the address.
interface sram_test_master_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   avm_address;
  logic [DATA_W/8-1:0] avm_byteenable;
  logic                avm_chipselect;
  logic                avm_write;
  logic [DATA_W-1:0]   avm_writedata;
  logic                avm_clken;
  logic [DATA_W-1:0]   avm_readdata;

  modport master (
    output avm_address,
    output avm_byteenable,
    output avm_chipselect,
    output avm_write,
    output avm_writedata,
    output avm_clken,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_byteenable,
    input  avm_chipselect,
    input  avm_write,
    input  avm_writedata,
    input  avm_clken,
    output avm_readdata
  );
endinterface

// File: rtl/sram_test_master.sv
// SRAM test master: writes an incrementing pattern over a region,
// reads it back, and counts mismatching words.
module sram_test_master #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  sram_test_master_if.master avm
);
  localparam int CW = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     n_q, n_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic              rd_vld_q, rd_vld_d;
  logic [CW-1:0]     rd_idx_q, rd_idx_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [CW-1:0]     err_q, err_d;
  logic [ADDR_W-1:0] ferr_q, ferr_d;
  logic              done_q, done_d;

  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_pat;
  logic [DATA_W-1:0] rd_pat;
  logic              last;
  logic              miss;

  assign cur_addr = base_q + cnt_q[ADDR_W-1:0];
  assign cur_pat  = seed_q + DATA_W'(cnt_q);
  assign rd_pat   = seed_q + DATA_W'(rd_idx_q);
  assign last     = (cnt_q == n_q - CW'(1));
  assign miss     = rd_vld_q
                 && (avm.avm_readdata != rd_pat);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    n_d       = n_q;
    base_d    = base_q;
    seed_d    = seed_q;
    rd_vld_d  = 1'b0;
    rd_idx_d  = rd_idx_q;
    rd_addr_d = rd_addr_q;
    err_d     = err_q;
    ferr_d    = ferr_q;
    done_d    = 1'b0;

    // err_q == 0 marks the first mismatch of the test
    if (miss) begin
      err_d = err_q + CW'(1);
      if (err_q == '0) begin
        ferr_d = rd_addr_q;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d = base_addr;
          n_d    = word_count;
          seed_d = seed;
          err_d  = '0;
          ferr_d = '0;
          cnt_d  = '0;
          if (word_count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        if (last) begin
          cnt_d   = '0;
          state_d = READ;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      READ: begin
        rd_vld_d  = 1'b1;
        rd_idx_d  = cnt_q;
        rd_addr_d = cur_addr;
        if (last) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DRAIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      n_q       <= '0;
      base_q    <= '0;
      seed_q    <= '0;
      rd_vld_q  <= 1'b0;
      rd_idx_q  <= '0;
      rd_addr_q <= '0;
      err_q     <= '0;
      ferr_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      n_q       <= n_d;
      base_q    <= base_d;
      seed_q    <= seed_d;
      rd_vld_q  <= rd_vld_d;
      rd_idx_q  <= rd_idx_d;
      rd_addr_q <= rd_addr_d;
      err_q     <= err_d;
      ferr_q    <= ferr_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    avm.avm_byteenable = '1;
    avm.avm_clken      = 1'b1;
    avm.avm_chipselect = 1'b0;
    avm.avm_write      = 1'b0;
    avm.avm_address    = '0;
    avm.avm_writedata  = '0;
    if (state_q == WRITE) begin
      avm.avm_chipselect = 1'b1;
      avm.avm_write      = 1'b1;
      avm.avm_address    = cur_addr;
      avm.avm_writedata  = cur_pat;
    end else if (state_q == READ) begin
      avm.avm_chipselect = 1'b1;
      avm.avm_address    = cur_addr;
    end
  end

  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign err_count      = err_q;
  assign first_err_addr = ferr_q;
endmodule

// File: tb/tb_sram_test_master.sv
// Directed bench for sram_test_master: SRAM model plus a
// scoreboard of expected bus cycles.
module tb_sram_test_master;
  localparam int AW = 12;
  localparam int DW = 32;

  typedef struct packed {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } bus_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   word_count = '0;
  logic [DW-1:0] seed = '0;
  logic          busy;
  logic          done;
  logic [AW:0]   err_count;
  logic [AW-1:0] first_err_addr;

  int   checks = 0;
  int   errors = 0;
  int   mode = 0;
  bus_t exp_q[$];
  logic [DW-1:0] mem [0:(1<<AW)-1];

  sram_test_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sram_test_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .base_addr      (base_addr),
    .word_count     (word_count),
    .seed           (seed),
    .busy           (busy),
    .done           (done),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .avm            (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // SRAM model; mode 1 corrupts 0x005/0x007, mode 2 is stuck at 0
  always @(posedge clk) begin
    if (bus.avm_chipselect && bus.avm_write)
      mem[bus.avm_address] <= bus.avm_writedata;
    if (bus.avm_chipselect && !bus.avm_write) begin
      case (mode)
        1: bus.avm_readdata <=
             (bus.avm_address == 12'h005 ||
              bus.avm_address == 12'h007)
             ? ~mem[bus.avm_address]
             : mem[bus.avm_address];
        2: bus.avm_readdata <= '0;
        default: bus.avm_readdata <= mem[bus.avm_address];
      endcase
    end else begin
      bus.avm_readdata <= 32'hDEAD_0BAD;
    end
  end

  always @(negedge clk) begin
    bus_t got;
    bus_t exp;
    chk("be_clken",
        {bus.avm_byteenable, bus.avm_clken},
        {4'hF, 1'b1});
    if (bus.avm_chipselect === 1'b1) begin
      got = {bus.avm_write, bus.avm_address,
             bus.avm_write ? bus.avm_writedata : '0};
      if (exp_q.size() == 0) begin
        chk("bus_unexpected", 64'(got), 64'h1_0000_0000_0000);
      end else begin
        exp = exp_q.pop_front();
        chk(exp.w ? "bus_write" : "bus_read",
            64'(got), 64'(exp));
      end
    end else begin
      chk("bus_idle",
          {bus.avm_chipselect, bus.avm_write,
           bus.avm_address, bus.avm_writedata}, '0);
    end
  end

  task automatic push_ops(input logic [AW-1:0] b,
                          input int n,
                          input logic [DW-1:0] s,
                          input int nw,
                          input int nr);
    bus_t t;
    for (int i = 0; i < nw && i < n; i++) begin
      t.w = 1'b1;
      t.a = b + AW'(i);
      t.d = s + DW'(i);
      exp_q.push_back(t);
    end
    for (int i = 0; i < nr && i < n; i++) begin
      t.w = 1'b0;
      t.a = b + AW'(i);
      t.d = '0;
      exp_q.push_back(t);
    end
  endtask

  task automatic run_test(input logic [AW-1:0] b,
                          input int n,
                          input logic [DW-1:0] s,
                          input int m,
                          input int e_err,
                          input logic [AW-1:0] e_ferr);
    int done_at;
    int extra;
    int busy_bad;
    int exp_done;
    logic exp_busy;
    mode = m;
    push_ops(b, n, s, n, n);
    @(negedge clk);
    base_addr  = b;
    word_count = (AW+1)'(n);
    seed       = s;
    start      = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    done_at  = -1;
    extra    = 0;
    busy_bad = 0;
    exp_done = (n == 0) ? 1 : 2 * n + 2;
    for (int c = 1; c <= 2 * n + 4; c++) begin
      @(negedge clk);
      exp_busy = (n != 0) && (c <= 2 * n + 1);
      if (busy !== exp_busy) busy_bad++;
      if (done === 1'b1) begin
        if (done_at < 0) done_at = c;
        else extra++;
      end
      // busy-time command and input changes must be ignored
      if (c == 2 && n >= 2) begin
        start      = 1'b1;
        base_addr  = AW'($urandom);
        word_count = (AW+1)'($urandom_range(1, 4096));
        seed       = $urandom;
      end
      if (c == 3) start = 1'b0;
    end
    chk("done_cycle", 64'(done_at), 64'(exp_done));
    chk("done_extra", 64'(extra), 64'd0);
    chk("busy_window", 64'(busy_bad), 64'd0);
    chk("err_count", 64'(err_count), 64'(e_err));
    chk("first_err_addr", 64'(first_err_addr), 64'(e_ferr));
    chk("ops_left", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_bad;
    int done_seen;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err_count), 64'd0);
    chk("rst_ferr", 64'(first_err_addr), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_test(12'h010, 4, 32'hA000_0000, 0, 0, 12'h000);
    chk("mem_0x013", 64'(mem[12'h013]), 64'h0A000_0003);
    run_test(12'hFFE, 4, 32'h0, 0, 0, 12'h000);
    run_test(12'h000, 8, 32'h1234_5678, 1, 2, 12'h005);
    repeat (3) @(negedge clk);
    chk("hold_err", 64'(err_count), 64'd2);
    chk("hold_ferr", 64'(first_err_addr), 64'h005);
    run_test(12'h300, 0, 32'h1, 0, 0, 12'h000);
    run_test(12'h000, 4096, 32'h1, 2, 4096, 12'h000);

    // abort: only the first three writes may reach the bus
    mode = 0;
    push_ops(12'h020, 8, 32'h55, 3, 0);
    @(negedge clk);
    base_addr  = 12'h020;
    word_count = 13'd8;
    seed       = 32'h55;
    start      = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    busy_bad  = 0;
    done_seen = 0;
    for (int c = 0; c < 24; c++) begin
      if (busy !== 1'b0) busy_bad++;
      if (done !== 1'b0) done_seen++;
      @(negedge clk);
    end
    chk("abort_busy", 64'(busy_bad), 64'd0);
    chk("abort_done", 64'(done_seen), 64'd0);
    chk("abort_ops", 64'(exp_q.size()), 64'd0);
    chk("abort_err", 64'(err_count), 64'd0);
    run_test(12'h100, 8, 32'hDEAD_BEEF, 0, 0, 12'h000);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_test_master.md
SRAM_TEST_MASTER -- requirements
Module: sram_test_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, word-address width of the target SRAM.
REQ-002 SHALL have parameter DATA_W, default 32, data width; byteenable width is DATA_W/8.
REQ-003 SHALL have port clk  in  1  single clock; all logic is rising-edge.
REQ-004 SHALL have port reset  in  1  reset; synchronous and active-high.
REQ-005 SHALL have port start  in  1  one-cycle command strobe; sampled only in IDLE.
REQ-006 SHALL have port base_addr  in  ADDR_W  first word address of the test region.
REQ-007 SHALL have port word_count  in  ADDR_W+1  region length in words, 0..2^ADDR_W.
REQ-008 SHALL have port seed  in  DATA_W  pattern seed.
REQ-009 SHALL have port busy  out  1  high while a test is in progress.
REQ-010 SHALL have port done  out  1  one-cycle completion pulse.
REQ-011 SHALL have port err_count  out  ADDR_W+1  number of mismatching words in the last test.
REQ-012 SHALL have port first_err_addr  out  ADDR_W  address of the first mismatch; 0 if none.
REQ-013 SHALL have port avm_address  out  ADDR_W  Avalon-MM word address to the SRAM slave.
REQ-014 SHALL have port avm_byteenable  out  DATA_W/8  byte enables; constant all-ones.
REQ-015 SHALL have port avm_chipselect  out  1  high on every bus cycle (write or read).
REQ-016 SHALL have port avm_write  out  1  write strobe.
REQ-017 SHALL have port avm_writedata  out  DATA_W  write data.
REQ-018 SHALL have port avm_clken  out  1  slave clock enable; constant 1.
REQ-019 SHALL have port avm_readdata  in  DATA_W  read data; valid exactly 1 cycle after a read address is presented; no waitrequest.

Function
REQ-020 SHALL implement FSM states IDLE, WRITE, READ, DRAIN.
REQ-021 IDLE: on start=1, SHALL latch base_addr, word_count and seed, clear err_count and first_err_addr, and go to WRITE (or stay in IDLE and pulse done next cycle if word_count=0).
REQ-022 Index i runs 0..N-1; address(i) SHALL be (base_addr + i) mod 2^ADDR_W, wrapping past the top of memory; pattern(i) SHALL be (seed + i) mod 2^DATA_W.
REQ-023 WRITE: one word per cycle: chipselect=1, write=1, address(i), writedata=pattern(i); after i=N-1, go to READ.
REQ-024 READ: one address per cycle: chipselect=1, write=0, address(i); after i=N-1, go to DRAIN.
REQ-025 Each read SHALL be tagged with i and address(i) through a 1-stage valid pipeline; the cycle after issue, avm_readdata SHALL be compared to pattern(i).
REQ-026 On a mismatch, err_count SHALL increment; on the first mismatch of a test, first_err_addr SHALL capture address(i).
REQ-027 DRAIN SHALL last 1 cycle (last compare), then go to IDLE with done=1 for exactly one cycle.
REQ-028 Timing with start sampled at edge 0: write cycles 1..N, read cycles N+1..2N, DRAIN 2N+1, done=1 in cycle 2N+2; busy=1 in cycles 1..2N+1 only.
REQ-029 start while busy SHALL be ignored; base_addr/word_count/seed changes while busy SHALL have no effect.
REQ-030 err_count and first_err_addr SHALL hold their values from done until the next accepted start.
REQ-031 Outside WRITE/READ, avm_chipselect and avm_write SHALL be 0; avm_address and avm_writedata SHALL be 0.
REQ-032 err_count SHALL NOT overflow (maximum 2^ADDR_W fits in ADDR_W+1 bits).

Reset
REQ-033 reset=1 at any edge SHALL force IDLE, busy=0, done=0, err_count=0, first_err_addr=0, chipselect=0, write=0, address=0, writedata=0, and clear the read pipeline.
REQ-034 Reset mid-test SHALL abort immediately with no further bus cycles; no done pulse SHALL be produced for the aborted test.
REQ-035 avm_byteenable=all-ones and avm_clken=1 SHALL hold during and after reset.

Verification
REQ-036 base=0x010, N=4, seed=0xA0000000, ideal SRAM model -> writes 0xA0000000..0xA0000003 to 0x010..0x013, reads same addresses, done in cycle 10, err_count=0, first_err_addr=0.
REQ-037 base=0xFFE, N=4, seed=0 -> addresses 0xFFE, 0xFFF, 0x000, 0x001 in both phases, err_count=0.
REQ-038 N=8, model corrupts read of 0x005 and 0x007 -> err_count=2, first_err_addr=0x005.
REQ-039 word_count=0, start -> no chipselect, busy stays 0, done=1 in cycle 1.
REQ-040 N=4096, base=0, slave stuck at 0, seed=1 -> err_count=4096, first_err_addr=0x000, done in cycle 8194.
REQ-041 reset at cycle 3 of an N=8 test, start re-asserted during busy beforehand -> bus idle from the next cycle, no done pulse, second start ignored; a new start after reset runs a clean test.
